// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NUM_OUT active-low resets one by one in index order,
// waiting for a per-stage ack (or an optional timeout) before moving to the next stage.
`timescale 1ns/1ps
module rst_seq #(
  parameter int NUM_OUT    = 4,
  parameter int ASSERT_CYC = 8,
  parameter int STAGE_DLY  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sw_rst_req,
  input  logic [NUM_OUT-1:0]         ack_i,
  output logic [NUM_OUT-1:0]         rst_out_n,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_OUT):0]   stage_o,
  output logic [NUM_OUT-1:0]         err_timeout
);

  localparam int MAX_AS  = (ASSERT_CYC > STAGE_DLY) ? ASSERT_CYC : STAGE_DLY;
  localparam int MAX_ALL = (MAX_AS > TIMEOUT) ? MAX_AS : TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam int SW      = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [SW-1:0]    STAGE_LAST  = SW'(NUM_OUT - 1);
  localparam bit               HAS_TO      = (TIMEOUT != 0);

  localparam logic [1:0] ST_ASSERT = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]      stage_reg, stage_next;
  logic [NUM_OUT-1:0] rst_reg, rst_next;
  logic [NUM_OUT-1:0] err_reg, err_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [NUM_OUT-1:0] stage_sel;
  logic               ack_cur;
  logic               advance;

  // One-hot decode of the current stage; avoids indexing with an oversized stage counter.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_sel
      assign stage_sel[gi] = (stage_reg == SW'(gi));
    end
  endgenerate

  assign ack_cur = |(ack_i & stage_sel);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stage_next = stage_reg;
    rst_next   = rst_reg;
    err_next   = err_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    advance    = 1'b0;
    if (sw_rst_req) begin
      state_next = ST_ASSERT;
      cnt_next   = '0;
      stage_next = '0;
      rst_next   = '0;
      err_next   = '0;
      busy_next  = 1'b1;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (cnt_reg == ASSERT_LAST) begin
            state_next = ST_GAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            rst_next   = rst_reg | stage_sel;
            state_next = ST_WAIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // Ack is checked first so a same-cycle timeout never flags an error.
          if (ack_cur) begin
            advance = 1'b1;
          end else if (HAS_TO && cnt_reg == TO_LAST) begin
            err_next = err_reg | stage_sel;
            advance  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          if (advance) begin
            cnt_next = '0;
            if (stage_reg == STAGE_LAST) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end else begin
              stage_next = stage_reg + SW'(1);
              state_next = ST_GAP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      stage_reg <= '0;
      rst_reg   <= '0;
      err_reg   <= '0;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stage_reg <= stage_next;
      rst_reg   <= rst_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign rst_out_n   = rst_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign stage_o     = stage_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: checkpoint table for full sequences plus hand-written corner cases.
`timescale 1ns/1ps
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] ack = 4'h0;
  logic [3:0] rst_out_n;
  logic       busy, done;
  logic [2:0] stage_o;
  logic [3:0] err_timeout;

  logic [3:0] ack2 = 4'h0;
  logic [3:0] rst_out2_n;
  logic       busy2, done2;
  logic [2:0] stage2;
  logic [3:0] err2;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  rst_seq dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .ack_i(ack),
    .rst_out_n(rst_out_n), .busy(busy), .done(done), .stage_o(stage_o),
    .err_timeout(err_timeout)
  );

  rst_seq #(.TIMEOUT(0)) dut_noto (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .ack_i(ack2),
    .rst_out_n(rst_out2_n), .busy(busy2), .done(done2), .stage_o(stage2),
    .err_timeout(err2)
  );

  typedef struct {
    bit         new_run;
    logic [3:0] ack;
    int         edge_n;
    logic [3:0] rst;
    logic       busy;
    logic       done;
    logic [2:0] stg;
    logic [3:0] err;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic step_to(input int n);
    while (edge_cnt < n) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r, input logic b, input logic d,
                         input logic [2:0] s, input logic [3:0] e);
    chk({tag, "_rst"},  32'(rst_out_n),   32'(r));
    chk({tag, "_busy"}, 32'(busy),        32'(b));
    chk({tag, "_done"}, 32'(done),        32'(d));
    chk({tag, "_stg"},  32'(stage_o),     32'(s));
    chk({tag, "_err"},  32'(err_timeout), 32'(e));
    $display("%s edge %0d: rst=%h busy=%b done=%b stg=%0d err=%h", tag, edge_cnt,
             rst_out_n, busy, done, stage_o, err_timeout);
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    edge_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ack tied high: releases at 12/17/22/27, done at 28
    vq.push_back('{1'b1, 4'hF,  0, 4'h0, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'hF, 11, 4'h0, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'hF, 12, 4'h1, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'hF, 13, 4'h1, 1'b1, 1'b0, 3'd1, 4'h0});
    vq.push_back('{1'b0, 4'hF, 16, 4'h1, 1'b1, 1'b0, 3'd1, 4'h0});
    vq.push_back('{1'b0, 4'hF, 17, 4'h3, 1'b1, 1'b0, 3'd1, 4'h0});
    vq.push_back('{1'b0, 4'hF, 18, 4'h3, 1'b1, 1'b0, 3'd2, 4'h0});
    vq.push_back('{1'b0, 4'hF, 22, 4'h7, 1'b1, 1'b0, 3'd2, 4'h0});
    vq.push_back('{1'b0, 4'hF, 27, 4'hF, 1'b1, 1'b0, 3'd3, 4'h0});
    vq.push_back('{1'b0, 4'hF, 28, 4'hF, 1'b0, 1'b1, 3'd3, 4'h0});
    vq.push_back('{1'b0, 4'hF, 40, 4'hF, 1'b0, 1'b1, 3'd3, 4'h0});
    // ack never comes: each stage takes 4 gap + 64 wait edges
    vq.push_back('{1'b1, 4'h0,   0, 4'h0, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'h0,  12, 4'h1, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'h0,  75, 4'h1, 1'b1, 1'b0, 3'd0, 4'h0});
    vq.push_back('{1'b0, 4'h0,  76, 4'h1, 1'b1, 1'b0, 3'd1, 4'h1});
    vq.push_back('{1'b0, 4'h0,  79, 4'h1, 1'b1, 1'b0, 3'd1, 4'h1});
    vq.push_back('{1'b0, 4'h0,  80, 4'h3, 1'b1, 1'b0, 3'd1, 4'h1});
    vq.push_back('{1'b0, 4'h0, 216, 4'hF, 1'b1, 1'b0, 3'd3, 4'h7});
    vq.push_back('{1'b0, 4'h0, 279, 4'hF, 1'b1, 1'b0, 3'd3, 4'h7});
    vq.push_back('{1'b0, 4'h0, 280, 4'hF, 1'b0, 1'b1, 3'd3, 4'hF});

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].new_run) begin
        rst_n = 1'b0;
        ack = vq[i].ack;
        step();
        step();
        edge_cnt = 0;
      end else begin
        step_to(vq[i].edge_n);
      end
      chk_all($sformatf("row%0d", i), vq[i].rst, vq[i].busy, vq[i].done, vq[i].stg, vq[i].err);
      if (vq[i].new_run) rst_n = 1'b1;
    end

    // Software re-sequence from DONE: same offsets from the request edge, errors cleared
    sw_pulse();
    chk_all("sw_req", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);
    ack = 4'hF;
    step_to(11); chk_all("sw_e11", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);
    step_to(12); chk_all("sw_e12", 4'h1, 1'b1, 1'b0, 3'd0, 4'h0);
    step_to(17); chk_all("sw_e17", 4'h3, 1'b1, 1'b0, 3'd1, 4'h0);
    step_to(22); chk_all("sw_e22", 4'h7, 1'b1, 1'b0, 3'd2, 4'h0);
    step_to(27); chk_all("sw_e27", 4'hF, 1'b1, 1'b0, 3'd3, 4'h0);
    step_to(28); chk_all("sw_e28", 4'hF, 1'b0, 1'b1, 3'd3, 4'h0);

    // Restart beats a same-cycle ack in WAIT_ACK of stage 1
    ack = 4'h1;
    sw_pulse();
    step_to(19); chk_all("race_wait1", 4'h3, 1'b1, 1'b0, 3'd1, 4'h0);
    ack = 4'h3;
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk_all("race_req", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);
    step();
    chk_all("race_next", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);

    // Async reset during GAP of stage 2, checked before the next clock edge
    ack = 4'hF;
    sw_pulse();
    step_to(20); chk_all("gap2", 4'h3, 1'b1, 1'b0, 3'd2, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    edge_cnt = 0;
    step_to(11); chk_all("rel_e11", 4'h0, 1'b1, 1'b0, 3'd0, 4'h0);
    step_to(12); chk_all("rel_e12", 4'h1, 1'b1, 1'b0, 3'd0, 4'h0);

    // TIMEOUT=0 instance: waits indefinitely, never flags an error
    ack2 = 4'h0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    edge_cnt = 0;
    step_to(12);
    chk("noto_e12_rst", 32'(rst_out2_n), 32'h1);
    step_to(1012);
    chk("noto_e1012_stg", 32'(stage2), 32'd0);
    chk("noto_e1012_err", 32'(err2), 32'h0);
    chk("noto_e1012_busy", 32'(busy2), 32'h1);
    $display("noto edge %0d: rst=%h stg=%0d err=%h", edge_cnt, rst_out2_n, stage2, err2);
    ack2 = 4'h1;
    step();
    chk("noto_ack_stg", 32'(stage2), 32'd1);
    chk("noto_ack_err", 32'(err2), 32'h0);
    chk("noto_ack_rst", 32'(rst_out2_n), 32'h1);
    step_to(1017);
    chk("noto_e1017_rst", 32'(rst_out2_n), 32'h3);
    chk("noto_e1017_err", 32'(err2), 32'h0);
    $display("noto edge %0d: rst=%h stg=%0d err=%h", edge_cnt, rst_out2_n, stage2, err2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
